// File: rtl/mmio_host_pkg.sv
// Shared types for the MMIO host requester: response status, FSM state, and the
// subset of the CCI-P Rx/Tx channel structures that an MMIO initiator touches.
package mmio_host_pkg;

  localparam int unsigned TidW = 9;

  typedef logic [15:0]     t_ccip_mmioAddr;
  typedef logic [1:0]      t_ccip_mmioLen;
  typedef logic [TidW-1:0] t_ccip_tid;

  typedef struct packed {
    t_ccip_mmioAddr address;
    t_ccip_mmioLen  length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [27:0] hdr;
    logic        rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  typedef enum logic [1:0] {
    RspOk       = 2'd0,
    RspTimeout  = 2'd1,
    RspTidErr   = 2'd2,
    RspAlignErr = 2'd3
  } t_mmio_rsp_status;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRdWait,
    StRsp
  } t_mmio_host_state;

endpackage

// File: rtl/mmio_host_requester_if.sv
// Command/response handshake between a test harness (master) and the MMIO
// host requester (slave).
interface mmio_host_requester_if;
  import mmio_host_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic             cmd_len8;
  logic [15:0]      cmd_addr;
  logic [63:0]      cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  t_mmio_rsp_status rsp_status;

  modport master (
    output cmd_valid, cmd_write, cmd_len8, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_len8, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_status
  );
endinterface

// File: rtl/mmio_host_requester.sv
// CCI-P MMIO initiator: issues one MMIO read/write at a time into the AFU's c0
// channel, checks the c2 read response and reports data/status/latency.
module mmio_host_requester
  import mmio_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned LAT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_host_requester_if.slave  host,
  output logic [LAT_WIDTH-1:0]  rd_latency,
  output logic                  err_unexpected,
  output t_if_ccip_Rx           rx,
  input  t_if_ccip_Tx           tx
);

  localparam logic [31:0] LatMax = (LAT_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << LAT_WIDTH) - 32'd1);

  t_mmio_host_state     state_q, state_d;
  t_ccip_tid            tid_q, tid_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 cmd_write_q, cmd_write_d;
  logic                 cmd_len8_q, cmd_len8_d;
  logic [15:0]          cmd_addr_q, cmd_addr_d;
  logic [63:0]          cmd_data_q, cmd_data_d;
  logic [63:0]          rsp_data_q, rsp_data_d;
  t_mmio_rsp_status     rsp_status_q, rsp_status_d;
  logic [LAT_WIDTH-1:0] rd_latency_q, rd_latency_d;
  logic                 err_unexpected_q, err_unexpected_d;

  always_comb begin
    state_d          = state_q;
    tid_d            = tid_q;
    cnt_d            = cnt_q;
    cmd_write_d      = cmd_write_q;
    cmd_len8_d       = cmd_len8_q;
    cmd_addr_d       = cmd_addr_q;
    cmd_data_d       = cmd_data_q;
    rsp_data_d       = rsp_data_q;
    rsp_status_d     = rsp_status_q;
    rd_latency_d     = rd_latency_q;
    err_unexpected_d = err_unexpected_q;

    unique case (state_q)
      StIdle: begin
        if (host.cmd_valid) begin
          cmd_write_d = host.cmd_write;
          cmd_len8_d  = host.cmd_len8;
          cmd_addr_d  = host.cmd_addr;
          cmd_data_d  = host.cmd_data;
          // 8-byte accesses must sit on an even 32-bit word; reject without bus traffic.
          if (host.cmd_len8 && host.cmd_addr[0]) begin
            rsp_data_d   = '0;
            rsp_status_d = RspAlignErr;
            state_d      = StRsp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (cmd_write_q) begin
          rsp_data_d   = '0;
          rsp_status_d = RspOk;
          state_d      = StRsp;
        end else begin
          cnt_d   = 32'd1;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        // A response on the timeout cycle takes priority over the timeout.
        if (tx.c2.mmioRdValid) begin
          rsp_data_d   = tx.c2.data;
          rsp_status_d = (tx.c2.hdr.tid == tid_q) ? RspOk : RspTidErr;
          rd_latency_d = LAT_WIDTH'((cnt_q > LatMax) ? LatMax : cnt_q);
          tid_d        = tid_q + 1'b1;
          state_d      = StRsp;
        end else if (cnt_q == TIMEOUT_CYCLES) begin
          rsp_data_d   = '0;
          rsp_status_d = RspTimeout;
          tid_d        = tid_q + 1'b1;
          state_d      = StRsp;
        end else if (cnt_q != 32'hFFFF_FFFF) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StRsp: begin
        if (host.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (tx.c2.mmioRdValid && (state_q != StRdWait)) err_unexpected_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      tid_q            <= '0;
      cnt_q            <= '0;
      cmd_write_q      <= 1'b0;
      cmd_len8_q       <= 1'b0;
      cmd_addr_q       <= '0;
      cmd_data_q       <= '0;
      rsp_data_q       <= '0;
      rsp_status_q     <= RspOk;
      rd_latency_q     <= '0;
      err_unexpected_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      tid_q            <= tid_d;
      cnt_q            <= cnt_d;
      cmd_write_q      <= cmd_write_d;
      cmd_len8_q       <= cmd_len8_d;
      cmd_addr_q       <= cmd_addr_d;
      cmd_data_q       <= cmd_data_d;
      rsp_data_q       <= rsp_data_d;
      rsp_status_q     <= rsp_status_d;
      rd_latency_q     <= rd_latency_d;
      err_unexpected_q <= err_unexpected_d;
    end
  end

  // Request fields decode straight from state so a reset drops them immediately.
  always_comb begin
    rx = '0;
    if (state_q == StIssue) begin
      rx.c0.hdr.address = cmd_addr_q;
      rx.c0.hdr.length  = {1'b0, cmd_len8_q};
      rx.c0.hdr.tid     = tid_q;
      rx.c0.data        = {448'd0, cmd_data_q};
      rx.c0.mmioWrValid = cmd_write_q;
      rx.c0.mmioRdValid = ~cmd_write_q;
    end
  end

  assign host.cmd_ready  = (state_q == StIdle);
  assign host.rsp_valid  = (state_q == StRsp);
  assign host.rsp_data   = rsp_data_q;
  assign host.rsp_status = rsp_status_q;
  assign rd_latency      = rd_latency_q;
  assign err_unexpected  = err_unexpected_q;

endmodule
